// File: rtl/sgbm_pkg.sv
// sgbm_pkg: shared types, default geometry and helpers for the SGBM
// disparity writer path.
package sgbm_pkg;

   // Writer control states.
   typedef enum logic [1:0] {
      SYNC = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } wr_state_e;

   localparam int unsigned DEF_IMG_W     = 400;
   localparam int unsigned DEF_IMG_H     = 200;
   localparam logic [31:0] DEF_BUF0_BASE = 32'h0000_0000;
   localparam logic [31:0] DEF_BUF1_BASE = 32'h0002_0000;

   // Widest byte-enable vector the helper below can describe.
   localparam int unsigned MAX_BE_W = 64;

   // Byte-enable mask covering the low `lanes` lanes of `bytes_per_lane` bytes each.
   function automatic logic [MAX_BE_W-1:0] lane_byte_en(input int unsigned lanes,
                                                        input int unsigned bytes_per_lane);
      logic [MAX_BE_W-1:0] be;
      be = {MAX_BE_W{1'b0}};
      for (int unsigned b = 0; b < MAX_BE_W; b++) begin
         if (b < lanes * bytes_per_lane) begin
            be[b] = 1'b1;
         end else begin
            be[b] = 1'b0;
         end
      end
      return be;
   endfunction

endpackage

// File: rtl/disp_packer.sv
// disp_packer: collects DISP_W-bit pixels into RAM_DW-bit words, lane 0 first.
// The word plus its byte enables is presented combinationally on the cycle
// the filling (or frame-final) pixel arrives; the caller registers it.
module disp_packer
   import sgbm_pkg::*;
#(
   parameter int unsigned DISP_W = 8,
   parameter int unsigned RAM_DW = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push_i,
   input  logic                  last_i,
   input  logic                  clear_i,
   input  logic [DISP_W-1:0]     pix_i,
   output logic                  fire_o,
   output logic [RAM_DW-1:0]     word_o,
   output logic [RAM_DW/8-1:0]   be_o
);

   localparam int unsigned PACK   = RAM_DW / DISP_W;
   localparam int unsigned BPW    = RAM_DW / 8;
   localparam int unsigned LBYTES = DISP_W / 8;
   localparam int unsigned CNT_W  = $clog2(PACK + 1);

   logic [RAM_DW-1:0]   data_q;
   logic [RAM_DW-1:0]   data_d;
   logic [CNT_W-1:0]    fill_q;
   logic [CNT_W-1:0]    fill_d;
   logic [RAM_DW-1:0]   merged_s;
   logic [MAX_BE_W-1:0] be_full_s;
   logic                full_s;

   // Merge the incoming pixel into its lane and decide whether the word goes out.
   always_comb begin
      merged_s = data_q;
      for (int unsigned l = 0; l < PACK; l++) begin
         if (push_i && (fill_q == CNT_W'(l))) begin
            merged_s[l*DISP_W +: DISP_W] = pix_i;
         end else begin
            merged_s[l*DISP_W +: DISP_W] = data_q[l*DISP_W +: DISP_W];
         end
      end
      full_s    = (fill_q == CNT_W'(PACK - 1));
      fire_o    = push_i && (full_s || last_i);
      be_full_s = lane_byte_en(32'(fill_q) + 32'd1, LBYTES);
      word_o    = merged_s;
      be_o      = be_full_s[BPW-1:0];
   end

   // Next lane contents: emptied after a flush or a discard, otherwise accumulate.
   always_comb begin
      if (clear_i) begin
         data_d = {RAM_DW{1'b0}};
         fill_d = {CNT_W{1'b0}};
      end else if (fire_o) begin
         data_d = {RAM_DW{1'b0}};
         fill_d = {CNT_W{1'b0}};
      end else if (push_i) begin
         data_d = merged_s;
         fill_d = fill_q + CNT_W'(1);
      end else begin
         data_d = data_q;
         fill_d = fill_q;
      end
   end

   // Lane storage and fill count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= {RAM_DW{1'b0}};
         fill_q <= {CNT_W{1'b0}};
      end else begin
         data_q <= data_d;
         fill_q <= fill_d;
      end
   end

endmodule

// File: rtl/disp_frame_writer.sv
// disp_frame_writer: writes the SGBM disparity stream into two ping-pong frame
// buffers through a BRAM-controller port and raises a per-frame interrupt.
module disp_frame_writer
   import sgbm_pkg::*;
#(
   parameter int unsigned       IMG_W     = DEF_IMG_W,
   parameter int unsigned       IMG_H     = DEF_IMG_H,
   parameter int unsigned       DISP_W    = 8,
   parameter int unsigned       RAM_DW    = 32,
   parameter int unsigned       ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BUF0_BASE = ADDR_W'(DEF_BUF0_BASE),
   parameter logic [ADDR_W-1:0] BUF1_BASE = ADDR_W'(DEF_BUF1_BASE)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid,
   input  logic [DISP_W-1:0]     disparity,
   input  logic [9:0]            row_in,
   input  logic [9:0]            col_in,
   input  logic                  intr_ack,
   output logic                  ram_clk,
   output logic                  ram_en,
   output logic [ADDR_W-1:0]     ram_addr,
   output logic [RAM_DW/8-1:0]   ram_we,
   output logic [RAM_DW-1:0]     ram_wr_data,
   output logic                  ram_rst,
   output logic                  intr,
   output logic                  done_buf,
   output logic                  ovr,
   output logic                  seq_err,
   output logic [15:0]           frame_cnt
);

   localparam int unsigned BPW = RAM_DW / 8;

   wr_state_e           state_q,     state_d;
   logic [9:0]          exp_row_q,   exp_row_d;
   logic [9:0]          exp_col_q,   exp_col_d;
   logic [ADDR_W-1:0]   offs_q,      offs_d;
   logic                wr_buf_q,    wr_buf_d;
   logic                intr_q,      intr_d;
   logic                ovr_q,       ovr_d;
   logic                seq_err_q,   seq_err_d;
   logic                done_buf_q,  done_buf_d;
   logic [15:0]         frame_cnt_q, frame_cnt_d;
   logic                ram_en_q,    ram_en_d;
   logic [ADDR_W-1:0]   ram_addr_q,  ram_addr_d;
   logic [BPW-1:0]      ram_we_q,    ram_we_d;
   logic [RAM_DW-1:0]   ram_data_q,  ram_data_d;
   logic                ram_rst_q,   ram_rst_d;

   logic                coord_ok_s;
   logic                last_pix_s;
   logic                accept_s;
   logic                seq_bad_s;
   logic                complete_s;
   logic                pk_fire_s;
   logic [RAM_DW-1:0]   pk_word_s;
   logic [BPW-1:0]      pk_be_s;

   // Classify the current pixel against the expected raster position.
   // In SYNC the counters sit at (0,0), so only a frame start is accepted.
   always_comb begin
      coord_ok_s = (row_in == exp_row_q) && (col_in == exp_col_q);
      last_pix_s = (exp_row_q == 10'(IMG_H - 1)) && (exp_col_q == 10'(IMG_W - 1));
      accept_s   = valid && coord_ok_s && (state_q != HOLD);
      seq_bad_s  = valid && !coord_ok_s && (state_q == RUN);
      complete_s = accept_s && last_pix_s;
   end

   disp_packer #(
      .DISP_W (DISP_W),
      .RAM_DW (RAM_DW)
   ) u_packer (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (accept_s),
      .last_i  (last_pix_s),
      .clear_i (seq_bad_s),
      .pix_i   (disparity),
      .fire_o  (pk_fire_s),
      .word_o  (pk_word_s),
      .be_o    (pk_be_s)
   );

   // Next-state logic: RAM write, raster counters, FSM and interrupt flags.
   always_comb begin
      state_d     = state_q;
      exp_row_d   = exp_row_q;
      exp_col_d   = exp_col_q;
      offs_d      = offs_q;
      wr_buf_d    = wr_buf_q;
      intr_d      = intr_q;
      ovr_d       = ovr_q;
      seq_err_d   = seq_err_q;
      done_buf_d  = done_buf_q;
      frame_cnt_d = frame_cnt_q;
      ram_en_d    = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_we_d    = {BPW{1'b0}};
      ram_data_d  = ram_data_q;
      ram_rst_d   = 1'b0;

      // A packed word leaves one cycle after the pixel that completed it.
      if (pk_fire_s) begin
         ram_en_d   = 1'b1;
         ram_addr_d = (wr_buf_q ? BUF1_BASE : BUF0_BASE) + offs_q;
         ram_data_d = pk_word_s;
         ram_we_d   = pk_be_s;
         if (complete_s) begin
            offs_d = {ADDR_W{1'b0}};
         end else begin
            offs_d = offs_q + ADDR_W'(BPW);
         end
      end else if (seq_bad_s) begin
         offs_d = {ADDR_W{1'b0}};
      end else begin
         offs_d = offs_q;
      end

      // Raster position expected for the next accepted pixel.
      if (seq_bad_s || complete_s) begin
         exp_row_d = 10'd0;
         exp_col_d = 10'd0;
      end else if (accept_s) begin
         if (exp_col_q == 10'(IMG_W - 1)) begin
            exp_col_d = 10'd0;
            exp_row_d = exp_row_q + 10'd1;
         end else begin
            exp_col_d = exp_col_q + 10'd1;
            exp_row_d = exp_row_q;
         end
      end else begin
         exp_row_d = exp_row_q;
         exp_col_d = exp_col_q;
      end

      case (state_q)
         SYNC: begin
            if (accept_s) begin
               state_d = RUN;
            end else begin
               state_d = SYNC;
            end
         end
         RUN: begin
            if (seq_bad_s) begin
               state_d   = SYNC;
               seq_err_d = 1'b1;
            end else begin
               state_d = RUN;
            end
         end
         HOLD: begin
            if (intr_ack) begin
               state_d = SYNC;
            end else begin
               state_d = HOLD;
            end
         end
         default: begin
            state_d = SYNC;
         end
      endcase

      // Completion takes priority over an acknowledge in the same cycle.
      if (complete_s) begin
         intr_d      = 1'b1;
         done_buf_d  = wr_buf_q;
         frame_cnt_d = frame_cnt_q + 16'd1;
         wr_buf_d    = ~wr_buf_q;
         if (intr_q && !intr_ack) begin
            ovr_d   = 1'b1;
            state_d = HOLD;
         end else begin
            ovr_d   = ovr_q;
            state_d = RUN;
         end
      end else if (intr_ack && intr_q) begin
         intr_d = 1'b0;
         ovr_d  = 1'b0;
      end else begin
         intr_d = intr_q;
         ovr_d  = ovr_q;
      end
   end

   // Control state and registered outputs; reset holds the RAM in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= SYNC;
         exp_row_q   <= 10'd0;
         exp_col_q   <= 10'd0;
         offs_q      <= {ADDR_W{1'b0}};
         wr_buf_q    <= 1'b0;
         intr_q      <= 1'b0;
         ovr_q       <= 1'b0;
         seq_err_q   <= 1'b0;
         done_buf_q  <= 1'b0;
         frame_cnt_q <= 16'd0;
         ram_en_q    <= 1'b0;
         ram_addr_q  <= {ADDR_W{1'b0}};
         ram_we_q    <= {BPW{1'b0}};
         ram_data_q  <= {RAM_DW{1'b0}};
         ram_rst_q   <= 1'b1;
      end else begin
         state_q     <= state_d;
         exp_row_q   <= exp_row_d;
         exp_col_q   <= exp_col_d;
         offs_q      <= offs_d;
         wr_buf_q    <= wr_buf_d;
         intr_q      <= intr_d;
         ovr_q       <= ovr_d;
         seq_err_q   <= seq_err_d;
         done_buf_q  <= done_buf_d;
         frame_cnt_q <= frame_cnt_d;
         ram_en_q    <= ram_en_d;
         ram_addr_q  <= ram_addr_d;
         ram_we_q    <= ram_we_d;
         ram_data_q  <= ram_data_d;
         ram_rst_q   <= ram_rst_d;
      end
   end

   assign ram_clk     = clk;
   assign ram_en      = ram_en_q;
   assign ram_addr    = ram_addr_q;
   assign ram_we      = ram_we_q;
   assign ram_wr_data = ram_data_q;
   assign ram_rst     = ram_rst_q;
   assign intr        = intr_q;
   assign done_buf    = done_buf_q;
   assign ovr         = ovr_q;
   assign seq_err     = seq_err_q;
   assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_disp_frame_writer.sv
// tb_disp_frame_writer: two writer instances (4x2 and 3x1 images) driven with
// directed pixel streams; an index-based frame model is compared every cycle,
// and hand-computed literals pin the expected RAM traffic.
module tb_disp_frame_writer;

   localparam int W_A = 4;
   localparam int H_A = 2;
   localparam int W_B = 3;
   localparam int H_B = 1;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  we;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]       valid_w;
   logic [1:0][7:0]  disp_w;
   logic [1:0][9:0]  row_w;
   logic [1:0][9:0]  col_w;
   logic [1:0]       ack_w;

   logic [1:0]       ram_clk_w;
   logic [1:0]       ram_en_w;
   logic [1:0][31:0] ram_addr_w;
   logic [1:0][3:0]  ram_we_w;
   logic [1:0][31:0] ram_data_w;
   logic [1:0]       ram_rst_w;
   logic [1:0]       intr_w;
   logic [1:0]       done_w;
   logic [1:0]       ovr_w;
   logic [1:0]       seq_w;
   logic [1:0][15:0] fcnt_w;

   disp_frame_writer #(
      .IMG_W(W_A), .IMG_H(H_A), .DISP_W(8), .RAM_DW(32), .ADDR_W(32),
      .BUF0_BASE(32'h0000_0000), .BUF1_BASE(32'h0000_0100)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .valid(valid_w[0]), .disparity(disp_w[0]),
      .row_in(row_w[0]), .col_in(col_w[0]), .intr_ack(ack_w[0]),
      .ram_clk(ram_clk_w[0]), .ram_en(ram_en_w[0]), .ram_addr(ram_addr_w[0]),
      .ram_we(ram_we_w[0]), .ram_wr_data(ram_data_w[0]), .ram_rst(ram_rst_w[0]),
      .intr(intr_w[0]), .done_buf(done_w[0]), .ovr(ovr_w[0]),
      .seq_err(seq_w[0]), .frame_cnt(fcnt_w[0])
   );

   disp_frame_writer #(
      .IMG_W(W_B), .IMG_H(H_B), .DISP_W(8), .RAM_DW(32), .ADDR_W(32),
      .BUF0_BASE(32'h0000_0000), .BUF1_BASE(32'h0000_0100)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .valid(valid_w[1]), .disparity(disp_w[1]),
      .row_in(row_w[1]), .col_in(col_w[1]), .intr_ack(ack_w[1]),
      .ram_clk(ram_clk_w[1]), .ram_en(ram_en_w[1]), .ram_addr(ram_addr_w[1]),
      .ram_we(ram_we_w[1]), .ram_wr_data(ram_data_w[1]), .ram_rst(ram_rst_w[1]),
      .intr(intr_w[1]), .done_buf(done_w[1]), .ovr(ovr_w[1]),
      .seq_err(seq_w[1]), .frame_cnt(fcnt_w[1])
   );

   int n_chk  = 0;
   int n_fail = 0;
   wr_t log0[$];
   wr_t log1[$];

   // Frame model: pixel index i, row = i / W, col = i % W, word = i / 4.
   int          m_idx    [2];
   bit          m_synced [2];
   bit          m_hold   [2];
   logic [7:0]  m_lane   [2][4];
   bit          m_intr   [2];
   bit          m_ovr    [2];
   bit          m_seq    [2];
   bit          m_done   [2];
   bit          m_wbuf   [2];
   bit          m_en     [2];
   bit          m_rst    [2];
   int          m_fcnt   [2];
   logic [31:0] m_addr   [2];
   logic [31:0] m_data   [2];
   logic [3:0]  m_we     [2];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset(input int d);
      m_idx[d] = 0; m_synced[d] = 1'b0; m_hold[d] = 1'b0;
      for (int k = 0; k < 4; k++) m_lane[d][k] = 8'h00;
      m_intr[d] = 1'b0; m_ovr[d] = 1'b0; m_seq[d] = 1'b0; m_done[d] = 1'b0;
      m_wbuf[d] = 1'b0; m_en[d] = 1'b0; m_rst[d] = 1'b1; m_fcnt[d] = 0;
      m_addr[d] = 32'h0; m_data[d] = 32'h0; m_we[d] = 4'h0;
   endtask

   task automatic model_step(input int d);
      int w, h, filled;
      bit last, done_frame;
      w = (d == 0) ? W_A : W_B;
      h = (d == 0) ? H_A : H_B;
      m_en[d] = 1'b0; m_we[d] = 4'h0; m_rst[d] = 1'b0; done_frame = 1'b0;
      if (m_hold[d]) begin
         if (ack_w[d]) begin
            m_hold[d] = 1'b0;
            m_synced[d] = 1'b0;
         end
      end else if (valid_w[d]) begin
         if (int'(row_w[d]) == m_idx[d] / w && int'(col_w[d]) == m_idx[d] % w) begin
            m_lane[d][m_idx[d] % 4] = disp_w[d];
            filled = m_idx[d] % 4 + 1;
            last = (m_idx[d] == w * h - 1);
            if (filled == 4 || last) begin
               m_en[d]   = 1'b1;
               m_addr[d] = (m_wbuf[d] ? 32'h100 : 32'h0) + 32'((m_idx[d] / 4) * 4);
               m_data[d] = 32'h0;
               for (int k = 0; k < filled; k++) m_data[d] = m_data[d] | (32'(m_lane[d][k]) << (8 * k));
               m_we[d]   = 4'((1 << filled) - 1);
               for (int k = 0; k < 4; k++) m_lane[d][k] = 8'h00;
            end
            m_synced[d] = 1'b1;
            if (last) begin
               done_frame = 1'b1;
               m_idx[d] = 0;
            end else begin
               m_idx[d]++;
            end
         end else if (m_synced[d]) begin
            m_seq[d] = 1'b1;
            m_idx[d] = 0;
            m_synced[d] = 1'b0;
            for (int k = 0; k < 4; k++) m_lane[d][k] = 8'h00;
         end
      end
      if (done_frame) begin
         m_done[d] = m_wbuf[d];
         m_fcnt[d] = (m_fcnt[d] + 1) % 65536;
         m_wbuf[d] = ~m_wbuf[d];
         if (m_intr[d] && !ack_w[d]) begin
            m_ovr[d] = 1'b1;
            m_hold[d] = 1'b1;
         end
         m_intr[d] = 1'b1;
      end else if (ack_w[d] && m_intr[d]) begin
         m_intr[d] = 1'b0;
         m_ovr[d] = 1'b0;
      end
   endtask

   task automatic compare(input int d);
      chk($sformatf("d%0d_ram_clk", d), 32'(ram_clk_w[d]), 32'(clk));
      chk($sformatf("d%0d_ram_en", d), 32'(ram_en_w[d]), 32'(m_en[d]));
      chk($sformatf("d%0d_ram_we", d), 32'(ram_we_w[d]), 32'(m_we[d]));
      chk($sformatf("d%0d_ram_rst", d), 32'(ram_rst_w[d]), 32'(m_rst[d]));
      chk($sformatf("d%0d_intr", d), 32'(intr_w[d]), 32'(m_intr[d]));
      chk($sformatf("d%0d_done_buf", d), 32'(done_w[d]), 32'(m_done[d]));
      chk($sformatf("d%0d_ovr", d), 32'(ovr_w[d]), 32'(m_ovr[d]));
      chk($sformatf("d%0d_seq_err", d), 32'(seq_w[d]), 32'(m_seq[d]));
      chk($sformatf("d%0d_frame_cnt", d), 32'(fcnt_w[d]), 32'(m_fcnt[d]));
      if (m_en[d]) begin
         chk($sformatf("d%0d_ram_addr", d), ram_addr_w[d], m_addr[d]);
         chk($sformatf("d%0d_ram_wr_data", d), ram_data_w[d], m_data[d]);
      end
      if (ram_en_w[d]) begin
         if (d == 0) log0.push_back({ram_addr_w[d], ram_data_w[d], ram_we_w[d]});
         else        log1.push_back({ram_addr_w[d], ram_data_w[d], ram_we_w[d]});
      end
   endtask

   // Model update on each rising edge, DUT comparison on each falling edge.
   initial begin
      forever begin
         @(posedge clk);
         for (int d = 0; d < 2; d++) begin
            if (!rst_n) model_reset(d);
            else        model_step(d);
         end
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (!rst_n) model_reset(d);
            compare(d);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pix(input int d, input int r, input int c, input logic [7:0] v);
      valid_w[d] = 1'b1;
      row_w[d]   = 10'(r);
      col_w[d]   = 10'(c);
      disp_w[d]  = v;
      @(posedge clk);
      #1;
      valid_w[d] = 1'b0;
   endtask

   task automatic frame(input int d, input logic [7:0] first, input bit ack_last);
      int w, h;
      w = (d == 0) ? W_A : W_B;
      h = (d == 0) ? H_A : H_B;
      for (int i = 0; i < w * h; i++) begin
         if (ack_last && i == w * h - 1) ack_w[d] = 1'b1;
         pix(d, i / w, i % w, first + 8'(i));
         ack_w[d] = 1'b0;
      end
   endtask

   task automatic ack(input int d);
      ack_w[d] = 1'b1;
      @(posedge clk);
      #1;
      ack_w[d] = 1'b0;
   endtask

   task automatic lit_wr(input string nm, input int d, input int k,
                         input logic [31:0] a, input logic [31:0] dat, input logic [3:0] we);
      wr_t e;
      int  sz;
      sz = (d == 0) ? log0.size() : log1.size();
      if (k < sz) begin
         e = (d == 0) ? log0[k] : log1[k];
         chk({nm, "_addr"}, e.addr, a);
         chk({nm, "_data"}, e.data, dat);
         chk({nm, "_we"}, 32'(e.we), 32'(we));
      end else begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: write %0d missing, only %0d logged", nm, k, sz);
      end
   endtask

   task automatic lit_status(input string nm, input int d, input bit i, input bit o,
                             input bit db, input int fc);
      chk({nm, "_intr"}, 32'(intr_w[d]), 32'(i));
      chk({nm, "_ovr"}, 32'(ovr_w[d]), 32'(o));
      chk({nm, "_done_buf"}, 32'(done_w[d]), 32'(db));
      chk({nm, "_frame_cnt"}, 32'(fcnt_w[d]), 32'(fc));
   endtask

   initial begin
      valid_w = 2'b00; ack_w = 2'b00;
      disp_w = '0; row_w = '0; col_w = '0;

      // Reset values.
      idle(3);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst%0d_ram_rst", d), 32'(ram_rst_w[d]), 32'd1);
         chk($sformatf("rst%0d_ram_en", d), 32'(ram_en_w[d]), 32'd0);
         chk($sformatf("rst%0d_ram_we", d), 32'(ram_we_w[d]), 32'd0);
         lit_status($sformatf("rst%0d", d), d, 1'b0, 1'b0, 1'b0, 0);
      end
      rst_n = 1'b1;
      idle(1);
      chk("rst_release_ram_rst", 32'(ram_rst_w[0]), 32'd0);

      // Pixels before any (0,0) are ignored.
      pix(0, 0, 1, 8'h55);
      pix(0, 1, 0, 8'h66);
      idle(2);
      chk("pre_sync_writes", 32'(log0.size()), 32'd0);

      // First frame into buffer 0.
      frame(0, 8'h10, 1'b0);
      idle(2);
      lit_wr("f1_w0", 0, 0, 32'h0, 32'h1312_1110, 4'hF);
      lit_wr("f1_w1", 0, 1, 32'h4, 32'h1716_1514, 4'hF);
      lit_status("f1", 0, 1'b1, 1'b0, 1'b0, 1);

      // Partial tail word on the 3x1 instance.
      frame(1, 8'h0A, 1'b0);
      idle(2);
      lit_wr("b_tail", 1, 0, 32'h0, 32'h000C_0B0A, 4'b0111);
      chk("b_writes", 32'(log1.size()), 32'd1);

      // Second frame without ack: buffer 1, overrun because intr still set.
      frame(0, 8'h20, 1'b0);
      idle(2);
      lit_wr("f2_w0", 0, 2, 32'h100, 32'h2322_2120, 4'hF);
      lit_wr("f2_w1", 0, 3, 32'h104, 32'h2726_2524, 4'hF);
      lit_status("f2", 0, 1'b1, 1'b1, 1'b1, 2);

      // Third frame is dropped while held.
      frame(0, 8'h30, 1'b0);
      idle(2);
      chk("hold_writes", 32'(log0.size()), 32'd4);
      lit_status("f3", 0, 1'b1, 1'b1, 1'b1, 2);

      // Ack releases the hold; writing resumes only at (0,0).
      ack(0);
      idle(1);
      lit_status("ack1", 0, 1'b0, 1'b0, 1'b1, 2);
      pix(0, 0, 1, 8'h77);
      pix(0, 0, 2, 8'h78);
      idle(2);
      chk("post_ack_writes", 32'(log0.size()), 32'd4);
      frame(0, 8'h40, 1'b0);
      idle(2);
      lit_wr("f4_w0", 0, 4, 32'h0, 32'h4342_4140, 4'hF);
      lit_status("f4", 0, 1'b1, 1'b0, 1'b0, 3);

      // Ack coincident with completion: completion wins.
      frame(0, 8'h50, 1'b1);
      idle(2);
      lit_wr("f5_w1", 0, 7, 32'h104, 32'h5756_5554, 4'hF);
      lit_status("f5", 0, 1'b1, 1'b0, 1'b1, 4);
      ack(0);
      idle(1);
      chk("ack2_intr", 32'(intr_w[0]), 32'd0);

      // Coordinate error discards the partial word.
      pix(0, 0, 0, 8'hE0);
      pix(0, 0, 1, 8'hE1);
      pix(0, 0, 3, 8'hE3);
      idle(2);
      chk("seq_err", 32'(seq_w[0]), 32'd1);
      chk("seq_writes", 32'(log0.size()), 32'd8);
      frame(0, 8'h60, 1'b0);
      idle(2);
      lit_wr("f6_w0", 0, 8, 32'h0, 32'h6362_6160, 4'hF);
      lit_status("f6", 0, 1'b1, 1'b0, 1'b0, 5);

      // Asynchronous reset mid-frame.
      pix(0, 0, 0, 8'h70);
      pix(0, 0, 1, 8'h71);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_ram_rst", 32'(ram_rst_w[0]), 32'd1);
      chk("arst_ram_en", 32'(ram_en_w[0]), 32'd0);
      chk("arst_ram_we", 32'(ram_we_w[0]), 32'd0);
      chk("arst_ram_addr", ram_addr_w[0], 32'h0);
      chk("arst_ram_data", ram_data_w[0], 32'h0);
      chk("arst_seq_err", 32'(seq_w[0]), 32'd0);
      lit_status("arst", 0, 1'b0, 1'b0, 1'b0, 0);
      idle(2);
      rst_n = 1'b1;
      idle(1);
      frame(0, 8'h80, 1'b0);
      idle(2);
      lit_wr("f7_w0", 0, 10, 32'h0, 32'h8382_8180, 4'hF);
      lit_wr("f7_w1", 0, 11, 32'h4, 32'h8786_8584, 4'hF);
      lit_status("f7", 0, 1'b1, 1'b0, 1'b0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
